// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: request/response handshake between a core and the data memory responder
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ctrl;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_ctrl, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_ctrl, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: byte-addressed little-endian data memory with fixed-latency valid/ready responses
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic                    clk,
  input logic                    rst,
  data_memory_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  logic [31:0] mem [DEPTH_WORDS];
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        err, fire;
  logic [AW-1:0] idx;
  logic [31:0] word, shifted, ld, wword;
  logic [15:0] half;
  logic [3:0]  be;
  assign idx     = addr_q[AW+1:2];
  assign word    = mem[idx];
  assign fire    = state_q == BUSY && cnt_q == 4'd0;
  assign err     = ctrl_q inside {3'b011, 3'b110, 3'b111}
                || (we_q && ctrl_q[2])
                || (ctrl_q[1:0] == 2'b01 && addr_q[0])
                || (ctrl_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00)
                || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
  assign shifted = word >> {addr_q[1:0], 3'b000};
  assign half    = addr_q[1] ? word[31:16] : word[15:0];
  assign ld      = ctrl_q == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]}
                 : ctrl_q == 3'b100 ? {24'b0, shifted[7:0]}
                 : ctrl_q == 3'b001 ? {{16{half[15]}}, half}
                 : ctrl_q == 3'b101 ? {16'b0, half}
                 : word;
  assign wword   = ctrl_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
                 : ctrl_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}}
                 : wdata_q;
  assign be      = ctrl_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
                 : ctrl_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011)
                 : 4'b1111;
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  // next state: capture in IDLE, count down in BUSY, latch the result on the last BUSY cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == IDLE && bus.req_valid) begin
      we_d    = bus.req_we;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      ctrl_d  = bus.req_ctrl;
      cnt_d   = 4'(LATENCY - 1);
      state_d = BUSY;
    end else if (fire) begin
      rdata_d = err || we_q ? 32'd0 : ld;
      err_d   = err;
      state_d = RESP;
    end else if (state_q == BUSY) begin
      cnt_d   = cnt_q - 4'd1;
    end else if (state_q == RESP && bus.resp_ready) begin
      state_d = IDLE;
    end
  end
  // state and captured request registers; reset wins over any transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ctrl_q  <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // storage is never cleared by reset; a store commits only on the BUSY->RESP edge
  always_ff @(posedge clk) begin
    if (!rst && fire && we_q && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench for the data memory responder
module tb_data_memory_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_memory_responder_if bus();
  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] q_rdata[$];
  logic        q_err[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic txn(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] ctrl, input logic [31:0] exp_d, input logic exp_e, input int hold);
    int n;
    logic [31:0] e_d;
    logic e_e;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_ctrl   = ctrl;
    bus.resp_ready = hold == 0;
    q_rdata.push_back(exp_d);
    q_err.push_back(exp_e);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = hold > 0;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h0;
    bus.req_ctrl  = 3'b010;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.resp_valid && n < 20);
    chk({tag, " latency"}, 32'(n), 32'd2);
    e_d = q_rdata.pop_front();
    e_e = q_err.pop_front();
    chk({tag, " rdata"}, bus.resp_rdata, e_d);
    chk({tag, " err"}, 32'(bus.resp_err), 32'(e_e));
    chk({tag, " busy"}, 32'(bus.req_ready), 32'd0);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk({tag, " hold valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, " hold rdata"}, bus.resp_rdata, e_d);
        chk({tag, " hold ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, " done valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, " done ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    if (hold > 0) begin
      @(posedge clk);
      #1;
      chk({tag, " no accept"}, 32'(bus.req_ready), 32'd1);
    end
  endtask
  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_ctrl   = 3'b000;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst valid", 32'(bus.resp_valid), 32'd0);
    chk("rst ready", 32'(bus.req_ready), 32'd1);
    chk("rst rdata", bus.resp_rdata, 32'd0);
    chk("rst err", 32'(bus.resp_err), 32'd0);
    txn("sw10",    1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        0, 0);
    txn("lw10",    0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0, 0);
    txn("lb13",    0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 0, 0);
    txn("lbu13",   0, 32'h13,  32'h0,        3'b100, 32'h000000DE, 0, 0);
    txn("lh12",    0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 0, 0);
    txn("lhu10",   0, 32'h10,  32'h0,        3'b101, 32'h0000BEEF, 0, 0);
    txn("sb11",    1, 32'h11,  32'h00000055, 3'b000, 32'h0,        0, 0);
    txn("lw10hld", 0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 0, 5);
    txn("lw10b",   0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 0, 0);
    txn("lw12mis", 0, 32'h12,  32'h0,        3'b010, 32'h0,        1, 0);
    txn("sh11mis", 1, 32'h11,  32'hFFFFFFFF, 3'b001, 32'h0,        1, 0);
    txn("lw10c",   0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 0, 0);
    txn("lw400",   0, 32'h400, 32'h0,        3'b010, 32'h0,        1, 0);
    txn("ctrl011", 0, 32'h10,  32'h0,        3'b011, 32'h0,        1, 0);
    txn("sbu",     1, 32'h10,  32'h0,        3'b100, 32'h0,        1, 0);
    txn("lw10d",   0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 0, 0);
    txn("sb3ff",   1, 32'h3FF, 32'h000000A5, 3'b000, 32'h0,        0, 0);
    txn("lbu3ff",  0, 32'h3FF, 32'h0,        3'b100, 32'h000000A5, 0, 0);
    txn("lb3ff",   0, 32'h3FF, 32'h0,        3'b000, 32'hFFFFFFA5, 0, 0);
    txn("sw20",    1, 32'h20,  32'hCAFEF00D, 3'b010, 32'h0,        0, 0);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h12345678;
    bus.req_ctrl   = 3'b010;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("busy rst valid", 32'(bus.resp_valid), 32'd0);
    chk("busy rst ready", 32'(bus.req_ready), 32'd1);
    chk("busy rst err", 32'(bus.resp_err), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("busy rst quiet", 32'(bus.resp_valid), 32'd0);
    end
    bus.resp_ready = 1'b0;
    txn("lw20", 0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
